// File: rtl/i2s_frame_packer.sv
// Packs one multi-channel PCM frame into a byte stream for the SPI TX FIFO.
// A frame is written only if the FIFO can hold all of it; refused frames are counted.
module i2s_frame_packer #(
    parameter int          NUM_CH   = 2,
    parameter int          SAMPLE_W = 24,
    parameter int          FREE_W   = 18,
    parameter int          DROP_W   = 16,
    parameter logic [7:0]  MARKER   = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pcm_valid,
    output logic                         pcm_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]   pcm_data,
    input  logic [1:0]                   cfg_bytes,
    input  logic [NUM_CH-1:0]            cfg_ch_en,
    input  logic                         cfg_marker_en,
    input  logic [FREE_W-1:0]            fifo_free,
    output logic                         fifo_wr_en,
    output logic [7:0]                   fifo_wr_data,
    input  logic                         drop_clr,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         frame_done
);

    localparam int BYTES_MAX = SAMPLE_W / 8;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REM_W     = $clog2(NUM_CH * BYTES_MAX + 2);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                        state_q, state_d;
    logic [NUM_CH*SAMPLE_W-1:0]    data_q, data_d;
    logic [NUM_CH-1:0]             en_q, en_d;
    logic [2:0]                    bytes_q, bytes_d;
    logic                          mark_q, mark_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [2:0]                    bidx_q, bidx_d;
    logic [REM_W-1:0]              rem_q, rem_d;
    logic [DROP_W-1:0]             drop_q, drop_d;

    logic [2:0]                    eff_b;
    logic [3:0]                    pop;
    logic [REM_W-1:0]              frame_len;
    logic [CH_W:0]                 first_ch, next_ch_r;
    logic [SAMPLE_W-1:0]           cur_sample;
    logic [7:0]                    cur_byte;
    int                            shamt;

    // Lowest enabled channel at or above start; MSB of the result flags "found".
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] en, input int start);
        find_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (c >= start && en[c]) find_ch = {1'b1, CH_W'(c)};
        end
    endfunction

    always_comb begin
        if (cfg_bytes == 2'd0)
            eff_b = 3'd1;
        else if ({1'b0, cfg_bytes} > 3'(BYTES_MAX))
            eff_b = 3'(BYTES_MAX);
        else
            eff_b = {1'b0, cfg_bytes};
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) pop = pop + 4'(cfg_ch_en[c]);
        frame_len = REM_W'(cfg_marker_en) + REM_W'(pop) * REM_W'(eff_b);
        first_ch  = find_ch(cfg_ch_en, 0);
        next_ch_r = find_ch(en_q, int'(ch_q) + 1);
    end

    // Sample is MSB-truncated to bytes_q bytes, then emitted LS byte first.
    always_comb begin
        cur_sample = data_q[int'(ch_q)*SAMPLE_W +: SAMPLE_W];
        shamt      = SAMPLE_W - 8 * (int'(bytes_q) - int'(bidx_q));
        cur_byte   = 8'(cur_sample >> shamt);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        bytes_d = bytes_q;
        mark_d  = mark_q;
        ch_d    = ch_q;
        bidx_d  = bidx_q;
        rem_d   = rem_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                if (pcm_valid && frame_len != '0) begin
                    if (fifo_free < FREE_W'(frame_len)) begin
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                    end else begin
                        state_d = EMIT;
                        data_d  = pcm_data;
                        en_d    = cfg_ch_en;
                        bytes_d = eff_b;
                        mark_d  = cfg_marker_en;
                        ch_d    = first_ch[CH_W-1:0];
                        bidx_d  = '0;
                        rem_d   = frame_len;
                    end
                end
            end
            EMIT: begin
                rem_d = rem_q - 1'b1;
                if (mark_q) begin
                    mark_d = 1'b0;
                end else if (bidx_q == bytes_q - 3'd1) begin
                    bidx_d = '0;
                    ch_d   = next_ch_r[CH_W-1:0];
                end else begin
                    bidx_d = bidx_q + 3'd1;
                end
                if (rem_q == REM_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (drop_clr) drop_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            en_q    <= '0;
            bytes_q <= '0;
            mark_q  <= 1'b0;
            ch_q    <= '0;
            bidx_q  <= '0;
            rem_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            bytes_q <= bytes_d;
            mark_q  <= mark_d;
            ch_q    <= ch_d;
            bidx_q  <= bidx_d;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
        end
    end

    assign pcm_ready    = (state_q == IDLE);
    assign fifo_wr_en   = (state_q == EMIT);
    assign fifo_wr_data = (state_q == EMIT) ? (mark_q ? MARKER : cur_byte) : 8'h00;
    assign frame_done   = (state_q == EMIT) && (rem_q == REM_W'(1));
    assign drop_count   = drop_q;

endmodule
